// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
// Module   : text_pkg (package)
// Purpose  : Shared constants and state encoding for the text tile RAM write
//            scheduler: tile RAM geometry, character width, clear character
//            and the scheduler state type.
// Revision : 1.0 - initial release
// ============================================================================
package text_pkg;

  localparam int ADDR_W    = 12;
  localparam int CHAR_W    = 7;
  localparam int NUM_COLS  = 80;
  localparam int NUM_ROWS  = 30;
  localparam int NUM_CELLS = NUM_COLS * NUM_ROWS;

  localparam logic [CHAR_W-1:0] CLEAR_CHAR = 7'h20;

  // Highest valid cell address; the clear counter stops here.
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

endpackage : text_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter. When enabled, grants at most one
//            requester (one-hot). On a tie the requester not granted last
//            wins. The last-grant pointer moves only when a grant is issued.
// Ports    : clk, reset (async, active-high)
//            en        - arbitration enable (slot and scheduler idle)
//            req[1:0]  - request vector
//            grant[1:0]- one-hot grant, combinational
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // 1 = requester 1 was granted most recently. Resets to 1 so that
  // requester 0 wins the first tie.
  logic r_last;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        grant = r_last ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (|grant) begin
      r_last <= grant[1];
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/text_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : text_wr_sched
// Purpose  : Write scheduler for the 80x30 character tile RAM. Shares the
//            single RAM write port between two requesters and a full-screen
//            clear engine, issuing at most one write per pixel-tick slot.
// Config   : TEXT_WR_BLANK_ONLY_EN - when defined, slots are restricted to
//            pixel ticks during blanking (p_tick & ~video_on).
// Ports    : clk, reset (async, active-high)
//            video_on, p_tick           - from VGA controller
//            req0_*/req1_*               - valid/ready write requesters
//            clear_start                 - pulse, starts full-screen clear
//            clear_busy, clear_done      - clear engine status
//            drop_err                    - pulse on dropped out-of-range write
//            ram_we, ram_addr, ram_wdata - registered tile RAM write port
// Revision : 1.0 - initial release
// ============================================================================
module text_wr_sched
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              video_on,
  input  logic              p_tick,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [CHAR_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [CHAR_W-1:0] req1_data,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              drop_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CHAR_W-1:0] ram_wdata
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;

  logic              w_tick_slot;
  logic              w_slot;
  logic              w_arb_en;
  logic [1:0]        w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [CHAR_W-1:0] w_data;
  logic              w_in_range;

`ifdef TEXT_WR_BLANK_ONLY_EN
  assign w_tick_slot = p_tick & ~video_on;
`else
  logic w_unused_video_on;
  assign w_unused_video_on = video_on;
  assign w_tick_slot       = p_tick;
`endif

  // A write lands one cycle after its slot, so masking with ram_we keeps the
  // write enable from ever being high on back-to-back cycles, even if p_tick
  // were asserted on adjacent cycles.
  assign w_slot = w_tick_slot & ~ram_we;

  // clear_start wins over any handshake in the same cycle.
  assign w_arb_en = w_slot & (r_state == S_IDLE) & ~clear_start;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (w_arb_en),
    .req   ({req1_valid, req0_valid}),
    .grant (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  assign w_addr     = w_grant[1] ? req1_addr : req0_addr;
  assign w_data     = w_grant[1] ? req1_data : req0_data;
  assign w_in_range = (w_addr <= LAST_CELL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clr_cnt  <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      drop_err   <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      ram_we     <= 1'b0;
      clear_done <= 1'b0;
      drop_err   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (clear_start) begin
            r_state    <= S_CLEAR;
            r_clr_cnt  <= '0;
            clear_busy <= 1'b1;
          end else if (|w_grant) begin
            // Out-of-range requests are accepted but never reach the RAM.
            if (w_in_range) begin
              ram_we    <= 1'b1;
              ram_addr  <= w_addr;
              ram_wdata <= w_data;
            end else begin
              drop_err  <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          // The final write's cycle carries clear_done; leave CLEAR after it.
          if (clear_done) begin
            r_state    <= S_IDLE;
            clear_busy <= 1'b0;
          end else if (w_slot) begin
            ram_we    <= 1'b1;
            ram_addr  <= r_clr_cnt;
            ram_wdata <= CLEAR_CHAR;
            if (r_clr_cnt == LAST_CELL) begin
              clear_done <= 1'b1;
            end else begin
              r_clr_cnt <= r_clr_cnt + 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule : text_wr_sched
`default_nettype wire

// File: tb/tb_text_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_wr_sched
// Purpose  : Self-checking bench for text_wr_sched. A behavioural model
//            derives the expected grants and RAM port activity from the
//            scheduler rules; scenario tasks compare the DUT against it and
//            against directed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_wr_sched;

  localparam int C_CELLS = 2400;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on;
  logic        p_tick;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [11:0] req0_addr, req1_addr;
  logic [6:0]  req0_data, req1_data;
  logic        clear_start;
  logic        clear_busy, clear_done, drop_err;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [6:0]  ram_wdata;

  int n_checks = 0;
  int n_errors = 0;
  int ph = 0;

  // Model state
  bit          m_clear, m_end, m_last;
  int          m_cnt;
  bit          e_rdy0, e_rdy1, obs_rdy0, obs_rdy1;
  bit          e_we, e_busy, e_done, e_drop;
  logic [11:0] e_addr;
  logic [6:0]  e_data;
  bit          n_we, n_busy, n_done, n_drop;
  logic [11:0] n_addr;
  logic [6:0]  n_data;

  always #5 clk = ~clk;

  text_wr_sched dut (
    .clk         (clk),
    .reset       (reset),
    .video_on    (video_on),
    .p_tick      (p_tick),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .drop_err    (drop_err),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata)
  );

  // p_tick is a one-in-four pulse, as from a 25 MHz enable on a 100 MHz clock.
  task automatic adv_phase();
    ph     = (ph + 1) % 4;
    p_tick = (ph == 0);
  endtask

  task automatic model_reset();
    m_clear = 0; m_end = 0; m_last = 1; m_cnt = 0;
    e_we = 0; e_busy = 0; e_done = 0; e_drop = 0;
    e_addr = '0; e_data = '0;
    e_rdy0 = 0; e_rdy1 = 0;
  endtask

  // Applies one cycle of scheduler rules to the current inputs.
  task automatic model_eval();
    bit slot, pick;
    int a;
`ifdef TEXT_WR_BLANK_ONLY_EN
    slot = p_tick && !video_on;
`else
    slot = p_tick;
`endif
    e_rdy0 = 0; e_rdy1 = 0;
    n_we = 0; n_done = 0; n_drop = 0;
    n_addr = e_addr; n_data = e_data; n_busy = e_busy;
    if (!m_clear) begin
      if (clear_start) begin
        m_clear = 1; m_end = 0; m_cnt = 0; n_busy = 1;
      end else if (slot && (req0_valid || req1_valid)) begin
        pick = (req0_valid && req1_valid) ? !m_last : req1_valid;
        m_last = pick;
        if (pick) e_rdy1 = 1; else e_rdy0 = 1;
        a = pick ? int'(req1_addr) : int'(req0_addr);
        if (a < C_CELLS) begin
          n_we = 1;
          n_addr = pick ? req1_addr : req0_addr;
          n_data = pick ? req1_data : req0_data;
        end else begin
          n_drop = 1;
        end
      end
    end else if (m_end) begin
      m_clear = 0; n_busy = 0;
    end else if (slot) begin
      n_we = 1; n_addr = 12'(m_cnt); n_data = 7'h20;
      if (m_cnt == C_CELLS - 1) begin
        n_done = 1; m_end = 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock: sample readiness before the edge, outputs 1 ns after it.
  task automatic step();
    #1;
    obs_rdy0 = req0_ready;
    obs_rdy1 = req1_ready;
    model_eval();
    @(posedge clk);
    #1;
    e_we = n_we; e_busy = n_busy; e_done = n_done; e_drop = n_drop;
    e_addr = n_addr; e_data = n_data;
    adv_phase();
  endtask

  task automatic idle_inputs();
    video_on = 0; req0_valid = 0; req1_valid = 0; clear_start = 0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (3) begin
      @(posedge clk); #1; adv_phase();
    end
    reset = 0;
    model_reset();
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 8 && !p_tick; i++) step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL reset_we got %b want 0", ram_we); end
    n_checks++; if (ram_addr !== 12'd0) begin n_errors++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
    n_checks++; if (ram_wdata !== 7'd0) begin n_errors++; $display("FAIL reset_wdata got %h want 0", ram_wdata); end
    n_checks++; if (clear_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", clear_busy); end
    n_checks++; if (clear_done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", clear_done); end
    n_checks++; if (drop_err !== 1'b0) begin n_errors++; $display("FAIL reset_drop got %b want 0", drop_err); end
  endtask

  task automatic test_single_write();
    do_reset();
    wait_tick();
    req0_valid = 1; req0_addr = 12'd5; req0_data = 7'h41;
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready got %b want 1", req0_ready); end
    step();
    req0_valid = 0;
    n_checks++; if (ram_we !== 1'b1) begin n_errors++; $display("FAIL single_we got %b want 1", ram_we); end
    n_checks++; if (ram_addr !== 12'd5) begin n_errors++; $display("FAIL single_addr got %0d want 5", ram_addr); end
    n_checks++; if (ram_wdata !== 7'h41) begin n_errors++; $display("FAIL single_data got %h want 41", ram_wdata); end
    step();
    n_checks++; if (ram_we !== 1'b0 || ram_addr !== 12'd5) begin
      n_errors++; $display("FAIL single_hold we=%b addr=%0d want we=0 addr=5", ram_we, ram_addr);
    end
  endtask

  task automatic test_round_robin();
    int order[4];
    int grants = 0;
    int wecnt  = 0;
    do_reset();
    req0_valid = 1; req0_addr = 12'd10; req0_data = 7'h10;
    req1_valid = 1; req1_addr = 12'd20; req1_data = 7'h20;
    for (int i = 0; i < 60 && grants < 4; i++) begin
      step();
      if (ram_we) wecnt++;
      n_checks++; if (obs_rdy0 && obs_rdy1) begin n_errors++; $display("FAIL rr_onehot both ready in step %0d", i); end
      if (obs_rdy0) begin order[grants] = 0; grants++; end
      else if (obs_rdy1) begin order[grants] = 1; grants++; end
    end
    req0_valid = 0; req1_valid = 0;
    repeat (6) begin step(); if (ram_we) wecnt++; end
    n_checks++; if (grants != 4) begin n_errors++; $display("FAIL rr_timeout got %0d grants want 4", grants); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k < grants && order[k] != (k % 2)) begin
        n_errors++; $display("FAIL rr_order grant %0d went to req%0d want req%0d", k, order[k], k % 2);
      end
    end
    n_checks++; if (wecnt != 4) begin n_errors++; $display("FAIL rr_we_count got %0d want 4", wecnt); end
  endtask

  task automatic test_out_of_range();
    int drops = 0;
    wait_tick();
    req1_valid = 1; req1_addr = 12'd2400; req1_data = 7'h33;
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL oor_ready got %b want 1", req1_ready); end
    step();
    req1_valid = 0;
    n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL oor_we got %b want 0", ram_we); end
    n_checks++; if (drop_err !== 1'b1) begin n_errors++; $display("FAIL oor_drop got %b want 1", drop_err); end
    if (drop_err) drops++;
    repeat (6) begin step(); if (drop_err) drops++; end
    n_checks++; if (drops != 1) begin n_errors++; $display("FAIL oor_drop_count got %0d want 1", drops); end
  endtask

  task automatic test_random();
    bit prev_we = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      video_on   = 1'($urandom % 2);
      req0_valid = 1'($urandom % 2);
      req1_valid = 1'($urandom % 2);
      req0_addr  = ($urandom % 4 == 0) ? 12'($urandom_range(2395, 4095)) : 12'($urandom_range(0, 2399));
      req1_addr  = ($urandom % 4 == 0) ? 12'($urandom_range(2395, 4095)) : 12'($urandom_range(0, 2399));
      req0_data  = 7'($urandom);
      req1_data  = 7'($urandom);
      step();
      n_checks++; if ({obs_rdy1, obs_rdy0} !== {e_rdy1, e_rdy0}) begin
        n_errors++; $display("FAIL rnd_ready step %0d got %b%b want %b%b", i, obs_rdy1, obs_rdy0, e_rdy1, e_rdy0);
      end
      n_checks++; if ({ram_we, drop_err, clear_busy, clear_done} !== {e_we, e_drop, e_busy, e_done}) begin
        n_errors++; $display("FAIL rnd_flags step %0d got we/drop/busy/done %b%b%b%b want %b%b%b%b",
                             i, ram_we, drop_err, clear_busy, clear_done, e_we, e_drop, e_busy, e_done);
      end
      n_checks++; if ({ram_addr, ram_wdata} !== {e_addr, e_data}) begin
        n_errors++; $display("FAIL rnd_port step %0d got %0d/%h want %0d/%h", i, ram_addr, ram_wdata, e_addr, e_data);
      end
      n_checks++; if (prev_we && ram_we) begin n_errors++; $display("FAIL rnd_we_b2b step %0d got consecutive writes", i); end
      prev_we = ram_we;
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int  wcount = 0;
    bit  done_seen = 0;
    int  done_cnt = 0;
    do_reset();
    wait_tick();
    req0_valid = 1; req0_addr = 12'd7; req0_data = 7'h55;
    clear_start = 1;
    step();
    clear_start = 0;
    n_checks++; if (obs_rdy0 !== 1'b0) begin n_errors++; $display("FAIL clr_priority req0_ready got %b want 0", obs_rdy0); end
    n_checks++; if (clear_busy !== 1'b1) begin n_errors++; $display("FAIL clr_busy_start got %b want 1", clear_busy); end
    for (int i = 0; i < 12000 && !done_seen; i++) begin
      req0_valid = 1'($urandom % 2);
      req1_valid = 1'($urandom % 2);
      req1_addr  = 12'($urandom_range(0, 2399));
      clear_start = ($urandom % 50 == 0);
      step();
      if (obs_rdy0 || obs_rdy1 || !clear_busy) begin
        n_checks++; n_errors++;
        $display("FAIL clr_state step %0d ready %b%b busy %b want 00 busy 1", i, obs_rdy1, obs_rdy0, clear_busy);
      end
      if (ram_we) begin
        n_checks++;
        if (ram_addr !== 12'(wcount) || ram_wdata !== 7'h20) begin
          n_errors++; $display("FAIL clr_write got %0d/%h want %0d/20", ram_addr, ram_wdata, wcount);
        end
        wcount++;
      end
      if (clear_done) begin
        done_seen = 1; done_cnt++;
        n_checks++;
        if (!ram_we || ram_addr !== 12'd2399) begin
          n_errors++; $display("FAIL clr_done_align we=%b addr=%0d want we=1 addr=2399", ram_we, ram_addr);
        end
      end
      n_checks++; if ({ram_we, clear_done, clear_busy} !== {e_we, e_done, e_busy}) begin
        n_errors++; $display("FAIL clr_model step %0d got %b%b%b want %b%b%b", i, ram_we, clear_done, clear_busy, e_we, e_done, e_busy);
      end
    end
    clear_start = 0;
    n_checks++; if (!done_seen) begin n_errors++; $display("FAIL clr_timeout wrote %0d cells with no clear_done", wcount); end
    n_checks++; if (wcount != C_CELLS) begin n_errors++; $display("FAIL clr_count got %0d want %0d", wcount, C_CELLS); end
    req0_valid = 0; req1_valid = 0;
    step();
    n_checks++; if (clear_busy !== 1'b0) begin n_errors++; $display("FAIL clr_busy_end got %b want 0", clear_busy); end
    repeat (8) begin step(); if (clear_done) done_cnt++; end
    n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL clr_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_clear_abort();
    int wcount = 0;
    int extra_done = 0;
    do_reset();
    clear_start = 1;
    step();
    clear_start = 0;
    for (int i = 0; i < 1000 && wcount < 100; i++) begin
      step();
      if (ram_we) wcount++;
    end
    n_checks++; if (wcount != 100) begin n_errors++; $display("FAIL abort_timeout got %0d writes want 100", wcount); end
    reset = 1;
    #1;
    n_checks++; if ({ram_we, clear_busy, clear_done, drop_err} !== 4'b0000) begin
      n_errors++; $display("FAIL abort_flags got %b%b%b%b want 0000", ram_we, clear_busy, clear_done, drop_err);
    end
    n_checks++; if (ram_addr !== 12'd0 || ram_wdata !== 7'd0) begin
      n_errors++; $display("FAIL abort_port got %0d/%h want 0/0", ram_addr, ram_wdata);
    end
    @(posedge clk); #1; adv_phase();
    reset = 0;
    model_reset();
    for (int i = 0; i < 60; i++) begin
      req0_valid = 1'($urandom % 2);
      req0_addr  = 12'($urandom_range(0, 2399));
      req0_data  = 7'($urandom);
      step();
      if (clear_done) extra_done++;
      n_checks++; if ({obs_rdy0, ram_we, clear_busy} !== {e_rdy0, e_we, e_busy}) begin
        n_errors++; $display("FAIL abort_idle step %0d got %b%b%b want %b%b%b", i, obs_rdy0, ram_we, clear_busy, e_rdy0, e_we, e_busy);
      end
    end
    n_checks++; if (extra_done != 0) begin n_errors++; $display("FAIL abort_done got %0d pulses want 0", extra_done); end
    idle_inputs();
  endtask

`ifdef TEXT_WR_BLANK_ONLY_EN
  task automatic test_blank();
    int seen = 0;
    bit granted = 0;
    do_reset();
    video_on = 1;
    req0_valid = 1; req0_addr = 12'd9; req0_data = 7'h42;
    for (int i = 0; i < 16; i++) begin
      step();
      if (obs_rdy0) seen++;
    end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL blank_active got %0d grants want 0", seen); end
    video_on = 0;
    for (int i = 0; i < 8 && !granted; i++) begin
      #1;
      if (p_tick) begin
        n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL blank_grant got %b want 1", req0_ready); end
        granted = 1;
      end
      step();
    end
    req0_valid = 0;
    n_checks++; if (!granted) begin n_errors++; $display("FAIL blank_timeout no p_tick seen"); end
  endtask
`endif

  initial begin
    reset = 1; p_tick = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_round_robin();
    test_out_of_range();
    test_random();
    test_clear();
    test_clear_abort();
`ifdef TEXT_WR_BLANK_ONLY_EN
    test_blank();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_text_wr_sched
`default_nettype wire
